coe_acc_bank: RTL

COE_ACC_BANK -- requirements
Module: coe_acc_bank

---
 rtl/coe_acc_bank.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/coe_acc_bank.sv
// Bank of signed saturating accumulators fed by a bit-serial term (LSB first).
// One lane is updated per operation: IDLE -> SHIFT (collect bits) -> ADD (one cycle).
module coe_acc_bank #(
   parameter int NUM_LANES      = 16,
   parameter int LANE_SEL_WIDTH = 4,
   parameter int TERM_WIDTH     = 8,
   parameter int ACC_WIDTH      = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [LANE_SEL_WIDTH-1:0]      lane_sel,
   input  logic                           sign_ctrl,
   input  logic                           bit_in,
   input  logic                           bit_valid,
   input  logic                           clear,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [NUM_LANES*ACC_WIDTH-1:0] acc_out,
   output logic [NUM_LANES-1:0]           ovf
);

   localparam int CNT_W = (TERM_WIDTH > 1) ? $clog2(TERM_WIDTH) : 1;
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SHIFT, ADD} state_t;

   state_t                     state, state_nxt;
   logic [LANE_SEL_WIDTH-1:0]  lane;
   logic                       sign;
   logic [TERM_WIDTH-1:0]      term;
   logic [CNT_W-1:0]           count;
   logic signed [ACC_WIDTH-1:0] acc [NUM_LANES];
   logic signed [ACC_WIDTH-1:0] acc_cur;
   logic [ACC_WIDTH:0]         add_res;
   logic                       lane_ok;
   logic                       accept;
   logic                       reject;
   logic                       bit_take;

   // Returns {overflow, clamped value}; one guard bit is enough because the
   // zero-extended term is always smaller in magnitude than the accumulator range.
   function automatic logic [ACC_WIDTH:0] sat_add(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic [TERM_WIDTH-1:0]       t,
      input logic                        sub
   );
      logic signed [ACC_WIDTH:0] ext_a;
      logic signed [ACC_WIDTH:0] ext_t;
      logic signed [ACC_WIDTH:0] sum;
      ext_a = {a[ACC_WIDTH-1], a};
      ext_t = {{(ACC_WIDTH+1-TERM_WIDTH){1'b0}}, t};
      sum   = sub ? (ext_a - ext_t) : (ext_a + ext_t);
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
         return {1'b1, (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
      return {1'b0, sum[ACC_WIDTH-1:0]};
   endfunction

   assign lane_ok = (int'(lane_sel) < NUM_LANES);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      bit_take  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (lane_ok) begin
                  accept    = 1'b1;
                  state_nxt = SHIFT;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (bit_valid) begin
               bit_take = 1'b1;
               if (count == CNT_W'(TERM_WIDTH-1)) state_nxt = ADD;
            end
         end
         ADD:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Clear aborts everything, including a pending start or ADD.
      if (clear) begin
         state_nxt = IDLE;
         accept    = 1'b0;
         reject    = 1'b0;
         bit_take  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane  <= '0;
         sign  <= 1'b0;
         term  <= '0;
         count <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= (state == ADD) && !clear;
         err  <= reject;
         if (clear) begin
            term  <= '0;
            count <= '0;
         end else if (accept) begin
            lane  <= lane_sel;
            sign  <= sign_ctrl;
            term  <= '0;
            count <= '0;
         end else if (bit_take) begin
            term[count] <= bit_in;
            count       <= count + 1'b1;
         end
      end
   end

   always_comb begin
      acc_cur = '0;
      for (int i = 0; i < NUM_LANES; i++)
         if (lane == LANE_SEL_WIDTH'(i)) acc_cur = acc[i];
   end

   assign add_res = sat_add(acc_cur, term, sign);

   // ADD stage: only the latched lane is written
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_LANES; i++) acc[i] <= '0;
         ovf <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_LANES; i++) acc[i] <= '0;
         ovf <= '0;
      end else if (state == ADD) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (lane == LANE_SEL_WIDTH'(i)) begin
               acc[i] <= add_res[ACC_WIDTH-1:0];
               if (add_res[ACC_WIDTH]) ovf[i] <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
      assign acc_out[g*ACC_WIDTH +: ACC_WIDTH] = acc[g];
   end

endmodule
